swap_scheduler: RTL



---
 rtl/swap_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/swap_scheduler.sv
// rtl/swap_scheduler.sv - swap-request FIFO and single-swap issue sequencer for the swap register file
//
// Queues swap requests (address pairs A/B) and issues them one at a time as a
// one-cycle swap pulse with registered address_A/address_B. Host writes are
// stalled (and dropped) while a swap is in flight. Host read/write addresses and
// write data pass straight through in every state.
//
// Optional feature macro: SWAP_SKIP_SAME_EN
//   defined     - an entry with A == B is popped and discarded without a swap
//   not defined - A == B entries are issued as ordinary swaps
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready               swap request handshake
//   req_addr_A, req_addr_B            addresses to exchange
//   host_we, host_addr_w, host_addr_r host write enable and addresses
//   host_data_w                       host write data
//   host_stall                        host write not accepted this cycle
//   we, address_w, address_r, data_w  register-file write/read port
//   swap, address_A, address_B        swap start pulse and current pair
//   busy                              swap in flight
//   level                             FIFO occupancy
//   swaps_done                        completed-swap counter (wraps)
module swap_scheduler #(
  parameter int ADDR_width  = 7,
  parameter int DATA_width  = 8,
  parameter int DEPTH       = 4,
  parameter int SWAP_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_width-1:0]      req_addr_A,
  input  logic [ADDR_width-1:0]      req_addr_B,
  input  logic                       host_we,
  input  logic [ADDR_width-1:0]      host_addr_w,
  input  logic [ADDR_width-1:0]      host_addr_r,
  input  logic [DATA_width-1:0]      host_data_w,
  output logic                       host_stall,
  output logic                       we,
  output logic [ADDR_width-1:0]      address_w,
  output logic [ADDR_width-1:0]      address_r,
  output logic [DATA_width-1:0]      data_w,
  output logic                       swap,
  output logic [ADDR_width-1:0]      address_A,
  output logic [ADDR_width-1:0]      address_B,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 swaps_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(SWAP_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  swap_q;
  logic [ADDR_width-1:0] addr_a_q;
  logic [ADDR_width-1:0] addr_b_q;
  logic [CW-1:0]         cnt_q;
  logic [7:0]            done_q;

  logic [ADDR_width-1:0] mem_a_q [DEPTH];
  logic [ADDR_width-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [LW-1:0]         level_q, level_d;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  skip;
  logic [ADDR_width-1:0] head_a;
  logic [ADDR_width-1:0] head_b;

  assign head_a = mem_a_q[rd_q];
  assign head_b = mem_b_q[rd_q];

`ifdef SWAP_SKIP_SAME_EN
  // Exchanging an address with itself is a no-op; drop it without occupying the file.
  assign skip = (head_a == head_b);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    push    = req_valid && !full;
    // A host write in IDLE wins over the pop; the pop retries next cycle.
    pop     = (state_q == S_IDLE) && !empty && !host_we;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Entry storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_q] <= req_addr_A;
      mem_b_q[wr_q] <= req_addr_B;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      swap_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      swap_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop && !skip) begin
            addr_a_q <= head_a;
            addr_b_q <= head_b;
            swap_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CW'(SWAP_CYCLES - 1);
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            done_q  <= done_q + 8'd1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = !full;
  assign busy       = (state_q != S_IDLE);
  assign host_stall = busy;
  assign we         = host_we && !busy;
  assign address_w  = host_addr_w;
  assign address_r  = host_addr_r;
  assign data_w     = host_data_w;
  assign swap       = swap_q;
  assign address_A  = addr_a_q;
  assign address_B  = addr_b_q;
  assign level      = level_q;
  assign swaps_done = done_q;

endmodule
